digit_counter: RTL and testbench
================================

Name: digit_counter

Overview:
Mixed-radix three-digit run/pause counter that produces the s0/s1/s2 digit values for the segment display stage directly downstream.
A prescaler derives a one-cycle tick from the system clock. Each tick advances a cascaded digit chain with carry.
Two one-cycle key pulses from the debounced key block start, pause, resume and clear the count.

Parameters:
CLK_DIV, 50_000_000, system clock cycles per tick (1 Hz at 50 MHz); legal range >= 2
MOD0, 6, modulus of digit s0; legal range 2..8
MOD1, 4, modulus of digit s1; legal range 2..4
MOD2, 8, modulus of digit s2; legal range 2..8
WRAP, 0, 1: roll over to 000 after the max count and keep running; 0: stop in DONE at the max count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_start  in  1  one-cycle pulse: start, pause or resume
key_clear  in  1  one-cycle pulse: clear to zero and stop
s0  out  3  least significant digit, 0..MOD0-1
s1  out  2  middle digit, 0..MOD1-1
s2  out  3  most significant digit, 0..MOD2-1
running  out  1  high while in RUN
done  out  1  high while in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values: state=IDLE, prescaler=0, s0=s1=s2=0, running=0, done=0. All outputs are registered.
- States and transitions (key_clear takes priority over everything except rst):
  - IDLE: key_start -> RUN.
  - RUN: key_start -> PAUSE; final tick with WRAP=0 -> DONE.
  - PAUSE: key_start -> RUN.
  - DONE: key_start -> RUN, with digits and prescaler zeroed in the same cycle.
  - Any state: key_clear -> IDLE, with digits and prescaler zeroed.
- Prescaler:
  - Width is $clog2(CLK_DIV).
  - Counts only in RUN. It is held, not cleared, in PAUSE, so resuming continues mid-period.
  - tick is asserted for one cycle when the prescaler equals CLK_DIV-1 in RUN; the prescaler returns to 0 on that cycle.
- Digit chain, on tick:
  - s0 increments. If s0==MOD0-1, s0 goes to 0 and carries into s1.
  - s1 and s2 follow the same rule with MOD1 and MOD2.
  - All three digits update on the same edge, one cycle after tick is asserted.
- Max count, where s0=MOD0-1, s1=MOD1-1, s2=MOD2-1:
  - WRAP=1: the next tick gives 000 and the counter stays in RUN.
  - WRAP=0: the next tick leaves the digits unchanged at max, and state goes to DONE.
- Latency:
  - key_start in IDLE: running=1 on the following edge. The first tick comes CLK_DIV cycles after entering RUN.
  - key_start in the same cycle as a tick in RUN: pause wins and the tick is discarded.
- Simultaneous key_start and key_clear: clear wins, so state goes to IDLE.
- rst asserted mid-count: all values return to their reset values on the next edge. No partial update.
- Digits never exceed modulus-1; out-of-range values are unreachable.

Decomposition:
- Shared package seg_pkg holds:
  - the state enum: IDLE, RUN, PAUSE, DONE;
  - the digit widths: 3, 2 and 3.
- One sub-module, mod_digit, implements a single digit. It is parameterised by modulus and width, takes inc and clr inputs, and outputs the digit value plus a carry that is asserted when inc is high at modulus-1.
- digit_counter instantiates mod_digit three times. It also contains the prescaler and the FSM.

Test Plan:
Common parameters for all scenarios: CLK_DIV=4, MOD0=6, MOD1=4, MOD2=8.
1. Reset, then key_start pulse -> running=1 next cycle. s0=1 exactly 4 cycles later. After 6 ticks: s0=0, s1=1, s2=0.
2. WRAP=0, run 191 ticks -> s2=7, s1=3, s0=5, running=1. 192nd tick -> digits unchanged, done=1, running=0. key_start -> RUN with digits 000.
3. WRAP=1, run 192 ticks -> digits 000, running=1, done=0.
4. Pause 2 cycles into a period -> digits and prescaler frozen for 10 cycles. Resume -> next tick 2 cycles later.
5. key_start and key_clear in the same cycle from RUN with s0=3 -> IDLE, digits 000, running=0.
6. rst asserted for 1 cycle mid-count with s1=2 -> all outputs 0 on the next edge. Count stays idle until key_start.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the run/pause digit counter: FSM state encoding
// and the fixed digit widths seen by the segment display stage.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_e;

    localparam int S0_W = 3;
    localparam int S1_W = 2;
    localparam int S2_W = 3;

endpackage

// File: rtl/mod_digit.sv
// One modulo-MOD digit of the cascaded counter chain. The carry fires in the
// same cycle as an increment at MOD-1, so the next digit steps on the same edge.
module mod_digit #(
    parameter int MOD = 6,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        // NOTE: value_d gets a default first so every path assigns it and no latch is inferred.
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = (value_q == LAST) ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && (value_q == LAST);

endmodule

// File: rtl/digit_counter.sv
// Three-digit mixed-radix run/pause counter: prescaler tick, run/pause/done FSM
// and a cascaded chain of mod_digit instances feeding the segment display.
module digit_counter
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int MOD0    = 6,
    parameter int MOD1    = 4,
    parameter int MOD2    = 8,
    parameter bit WRAP    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_start,
    input  logic            key_clear,
    output logic [S0_W-1:0] s0,
    output logic [S1_W-1:0] s1,
    output logic [S2_W-1:0] s2,
    output logic            running,
    output logic            done
);

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic          running_q;
    logic          done_q;

    logic tick;
    logic at_max;
    logic hold_max;
    logic digit_clr;
    logic inc0;
    logic carry0;
    logic carry1;
    logic carry2_unused;

    // A key press in a tick cycle pauses (or clears) instead of counting.
    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST) && !key_start && !key_clear;

    assign at_max = (s0 == S0_W'(MOD0 - 1)) &&
                    (s1 == S1_W'(MOD1 - 1)) &&
                    (s2 == S2_W'(MOD2 - 1));

    assign hold_max  = at_max && !WRAP;
    assign inc0      = tick && !hold_max;
    assign digit_clr = key_clear || ((state_q == DONE) && key_start);

    mod_digit #(.MOD(MOD0), .W(S0_W)) u_digit0 (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc0),
        .clr_i   (digit_clr),
        .value_o (s0),
        .carry_o (carry0)
    );

    mod_digit #(.MOD(MOD1), .W(S1_W)) u_digit1 (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (carry0),
        .clr_i   (digit_clr),
        .value_o (s1),
        .carry_o (carry1)
    );

    mod_digit #(.MOD(MOD2), .W(S2_W)) u_digit2 (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (carry1),
        .clr_i   (digit_clr),
        .value_o (s2),
        .carry_o (carry2_unused)
    );

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (key_start) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                        if (hold_max) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    // Prescaler is held here so a resume finishes the interrupted period.
                    if (key_start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (key_start) begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_digit_counter.sv
// Self-checking bench for digit_counter: a WRAP=0 and a WRAP=1 instance share
// stimulus and are compared against an integer-count reference model.
module tb_digit_counter;

    localparam int CLK_DIV = 4;
    localparam int MOD0    = 6;
    localparam int MOD1    = 4;
    localparam int MOD2    = 8;
    localparam int MAXC    = MOD0 * MOD1 * MOD2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        int mode;
        int phase;
        int count;
    } model_t;

    typedef struct {
        bit r;
        bit ks;
        bit kc;
        int s0;
        int s1;
        int s2;
        bit run;
        bit dn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_start = 1'b0;
    logic key_clear = 1'b0;

    logic [2:0] a_s0, b_s0;
    logic [1:0] a_s1, b_s1;
    logic [2:0] a_s2, b_s2;
    logic       a_run, b_run, a_done, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    model_t ma = '{M_IDLE, 0, 0};
    model_t mb = '{M_IDLE, 0, 0};

    vec_t vecs[11];

    always #5 clk = ~clk;

    digit_counter #(.CLK_DIV(CLK_DIV), .MOD0(MOD0), .MOD1(MOD1), .MOD2(MOD2), .WRAP(1'b0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_clear (key_clear),
        .s0        (a_s0),
        .s1        (a_s1),
        .s2        (a_s2),
        .running   (a_run),
        .done      (a_done)
    );

    digit_counter #(.CLK_DIV(CLK_DIV), .MOD0(MOD0), .MOD1(MOD1), .MOD2(MOD2), .WRAP(1'b1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_clear (key_clear),
        .s0        (b_s0),
        .s1        (b_s1),
        .s2        (b_s2),
        .running   (b_run),
        .done      (b_done)
    );

    function automatic model_t model_next(model_t m, bit wrap, bit r, bit ks, bit kc);
        model_t n;
        n = m;
        if (r || kc) begin
            n.mode  = M_IDLE;
            n.phase = 0;
            n.count = 0;
        end else begin
            case (m.mode)
                M_IDLE:  if (ks) n.mode = M_RUN;
                M_RUN: begin
                    if (ks) begin
                        n.mode = M_PAUSE;
                    end else if (m.phase == CLK_DIV - 1) begin
                        n.phase = 0;
                        if (m.count == MAXC - 1) begin
                            if (wrap) n.count = 0;
                            else      n.mode  = M_DONE;
                        end else begin
                            n.count = m.count + 1;
                        end
                    end else begin
                        n.phase = m.phase + 1;
                    end
                end
                M_PAUSE: if (ks) n.mode = M_RUN;
                default: begin
                    if (ks) begin
                        n.mode  = M_RUN;
                        n.phase = 0;
                        n.count = 0;
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic [9:0] model_vec(model_t m);
        return {3'(m.count / (MOD0 * MOD1)), 2'((m.count / MOD0) % MOD1), 3'(m.count % MOD0),
                m.mode == M_RUN, m.mode == M_DONE};
    endfunction

    function automatic logic [9:0] pack(int s2v, int s1v, int s0v, bit runv, bit dnv);
        return {3'(s2v), 2'(s1v), 3'(s0v), runv, dnv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance both models, sample #1 after the edge.
    task automatic step(input bit r, input bit ks, input bit kc);
        rst       = r;
        key_start = ks;
        key_clear = kc;
        @(posedge clk);
        ma = model_next(ma, 1'b0, r, ks, kc);
        mb = model_next(mb, 1'b1, r, ks, kc);
        #1;
        check("model_a", {22'd0, a_s2, a_s1, a_s0, a_run, a_done}, {22'd0, model_vec(ma)});
        check("model_b", {22'd0, b_s2, b_s1, b_s0, b_run, b_done}, {22'd0, model_vec(mb)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_a(input string name, input logic [9:0] exp);
        check(name, {22'd0, a_s2, a_s1, a_s0, a_run, a_done}, {22'd0, exp});
    endtask

    task automatic expect_b(input string name, input logic [9:0] exp);
        check(name, {22'd0, b_s2, b_s1, b_s0, b_run, b_done}, {22'd0, exp});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0};

        // Reset, start latency, first tick after CLK_DIV cycles, pause/resume/clear.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].ks, vecs[i].kc);
            expect_a($sformatf("vec%0d_a", i), pack(vecs[i].s2, vecs[i].s1, vecs[i].s0, vecs[i].run, vecs[i].dn));
            expect_b($sformatf("vec%0d_b", i), pack(vecs[i].s2, vecs[i].s1, vecs[i].s0, vecs[i].run, vecs[i].dn));
        end

        // Six ticks carry s0 into s1.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(6 * CLK_DIV);
        expect_a("six_ticks", pack(0, 1, 0, 1'b1, 1'b0));

        // Max count: WRAP=0 stops in DONE, WRAP=1 rolls over.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle((MAXC - 1) * CLK_DIV);
        expect_a("max_a", pack(7, 3, 5, 1'b1, 1'b0));
        expect_b("max_b", pack(7, 3, 5, 1'b1, 1'b0));
        idle(CLK_DIV);
        expect_a("done_a", pack(7, 3, 5, 1'b0, 1'b1));
        expect_b("wrap_b", pack(0, 0, 0, 1'b1, 1'b0));
        idle(3 * CLK_DIV);
        expect_a("done_hold_a", pack(7, 3, 5, 1'b0, 1'b1));
        step(1'b0, 1'b1, 1'b0);
        expect_a("done_restart_a", pack(0, 0, 0, 1'b1, 1'b0));
        idle(CLK_DIV);
        expect_a("restart_tick_a", pack(0, 0, 1, 1'b1, 1'b0));

        // Pause two cycles into a period; resume finishes the same period.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        expect_a("paused", pack(0, 0, 0, 1'b0, 1'b0));
        idle(10);
        expect_a("pause_frozen", pack(0, 0, 0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0);
        expect_a("resumed", pack(0, 0, 0, 1'b1, 1'b0));
        idle(1);
        expect_a("resume_plus1", pack(0, 0, 0, 1'b1, 1'b0));
        idle(1);
        expect_a("resume_plus2", pack(0, 0, 1, 1'b1, 1'b0));

        // Simultaneous start and clear while running.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(3 * CLK_DIV);
        expect_a("s0_three", pack(0, 0, 3, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b1);
        expect_a("start_clear", pack(0, 0, 0, 1'b0, 1'b0));

        // Reset mid-count, then stays idle until a start.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(12 * CLK_DIV);
        expect_a("s1_two", pack(0, 2, 0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0);
        expect_a("mid_reset", pack(0, 0, 0, 1'b0, 1'b0));
        idle(3 * CLK_DIV);
        expect_a("stay_idle", pack(0, 0, 0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0);
        expect_a("idle_start", pack(0, 0, 0, 1'b1, 1'b0));

        // Random key traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 500) == 0, ($urandom % 12) == 0, ($urandom % 150) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
